// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial load/store engine over an 8-bit data memory port
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_wd,
  output logic              mem_we,
  input  logic [7:0]        mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, err_q, err_d, ok, last;
  logic [2:0] f3_q, f3_d;
  logic [1:0] k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, lbuf_q, lbuf_d, rdata_q, rdata_d;
  always_comb begin
    ok = funct3[1:0] != 2'b11 && funct3[2:1] != 2'b11 && !(we && funct3[2])
      && !(funct3[1:0] == 2'b01 && addr[0]) && !(funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    last = k_q == (f3_q[1] ? 2'd3 : {1'b0, f3_q[0]});
    state_d = state_q;
    we_d = we_q;
    err_d = err_q;
    f3_d = f3_q;
    k_d = k_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    lbuf_d = lbuf_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && req) begin
      state_d = ok ? ACCESS : DONE;
      err_d = !ok;
      we_d = we;
      f3_d = funct3;
      addr_d = addr;
      wdata_d = wdata;
      k_d = 2'd0;
    end else if (state_q == ACCESS) begin
      k_d = last ? 2'd0 : k_q + 2'd1;
      if (!we_q) lbuf_d[{k_q, 3'b000} +: 8] = mem_rd;
      state_d = last ? DONE : ACCESS;
      // the final byte is merged and extended on the same edge so rdata is valid with done
      if (last && !we_q)
        rdata_d = f3_q[1] ? lbuf_d
                : f3_q[0] ? {{16{lbuf_d[15] & !f3_q[2]}}, lbuf_d[15:0]}
                : {{24{lbuf_d[7] & !f3_q[2]}}, lbuf_d[7:0]};
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      err_q <= 1'b0;
      f3_q <= 3'd0;
      k_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= 32'd0;
      lbuf_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      err_q <= err_d;
      f3_q <= f3_d;
      k_q <= k_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      lbuf_q <= lbuf_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = done && err_q;
  assign rdata = rdata_q;
  assign mem_we = state_q == ACCESS && we_q;
  assign mem_a = state_q == ACCESS ? addr_q + ADDR_W'(k_q) : '0;
  assign mem_wd = mem_we ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, random ops against a byte-array model, and reset/back-to-back sequences
module tb_load_store_unit;
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic [2:0] funct3 = 0;
  logic [7:0] addr = 0;
  logic [31:0] wdata = 0;
  logic busy, done, err, mem_we;
  logic [31:0] rdata;
  logic [7:0] mem_a, mem_wd, mem_rd;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [31:0] ref_rdata = 0;
  logic init_we = 0;
  logic [7:0] init_a = 0, init_d = 0;
  int compared = 0, mismatched = 0;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    if (init_we) mem[init_a] <= init_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit rejected(input bit w, input logic [2:0] f, input logic [7:0] a);
    int sz;
    if (!(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1;
    if (w && f[2]) return 1;
    sz = 1 << f[1:0];
    return (int'(a) % sz) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [7:0] a);
    int sz;
    longint v;
    sz = 1 << f[1:0];
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[8'(int'(a) + i)]) << (8 * i);
    if (!f[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return 32'(v);
  endfunction

  task automatic do_op(input bit w, input logic [2:0] f, input logic [7:0] a, input logic [31:0] d,
                       output logic act_err, output logic [31:0] act_rdata);
    bit rej, path_ok;
    int sz, cyc, diffs;
    rej = rejected(w, f, a);
    sz = 1 << f[1:0];
    @(negedge clk);
    req = 1; we = w; funct3 = f; addr = a; wdata = d;
    @(negedge clk);
    req = 0; we = 1'($urandom); funct3 = 3'($urandom); addr = 8'($urandom); wdata = $urandom;
    cyc = 1;
    path_ok = 1;
    while (!done && cyc < 12) begin
      if (!rej && w)
        path_ok &= mem_we === 1'b1 && mem_a === 8'(int'(a) + cyc - 1) && mem_wd === 8'(d >> (8 * (cyc - 1)));
      else
        path_ok &= mem_we === 1'b0 && mem_wd === 8'h00;
      @(negedge clk);
      cyc++;
    end
    if (!rej && w) for (int i = 0; i < sz; i++) ref_mem[8'(int'(a) + i)] = 8'(d >> (8 * i));
    if (!rej && !w) ref_rdata = load_val(f, a);
    act_err = err;
    act_rdata = rdata;
    chk("latency", 32'(cyc), rej ? 32'd1 : 32'(sz + 1));
    chk("err", {31'd0, err}, {31'd0, rej});
    chk("busy in done", {31'd0, busy}, 32'd1);
    chk("access path", {31'd0, path_ok}, 32'd1);
    chk("rdata", rdata, ref_rdata);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("memory bytes differing", 32'(diffs), 32'd0);
    @(negedge clk);
    chk("done one cycle", {31'd0, done}, 32'd0);
    chk("err without done", {31'd0, err}, 32'd0);
  endtask

  typedef struct {
    bit w;
    logic [2:0] f;
    logic [7:0] a;
    logic [31:0] d;
    bit e;
    logic [31:0] r;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic e;
    logic [31:0] r;
    int n_done;
    bit prev, adj, saw_done;
    tbl[0]  = '{1, 3'b010, 8'h10, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[1]  = '{0, 3'b010, 8'h10, 32'h0,        0, 32'hDEADBEEF};
    tbl[2]  = '{0, 3'b000, 8'h13, 32'h0,        0, 32'hFFFFFFDE};
    tbl[3]  = '{0, 3'b100, 8'h13, 32'h0,        0, 32'h000000DE};
    tbl[4]  = '{0, 3'b001, 8'h12, 32'h0,        0, 32'hFFFFDEAD};
    tbl[5]  = '{0, 3'b101, 8'h12, 32'h0,        0, 32'h0000DEAD};
    tbl[6]  = '{0, 3'b010, 8'h11, 32'h0,        1, 32'h0000DEAD};
    tbl[7]  = '{1, 3'b001, 8'h03, 32'h12345678, 1, 32'h0000DEAD};
    tbl[8]  = '{1, 3'b100, 8'h20, 32'h12345678, 1, 32'h0000DEAD};
    tbl[9]  = '{1, 3'b010, 8'hFC, 32'h11223344, 0, 32'h0000DEAD};
    tbl[10] = '{0, 3'b010, 8'hFC, 32'h0,        0, 32'h11223344};
    tbl[11] = '{0, 3'b001, 8'h10, 32'h0,        0, 32'hFFFFBEEF};
    tbl[12] = '{0, 3'b000, 8'h11, 32'h0,        0, 32'hFFFFFFBE};
    tbl[13] = '{0, 3'b011, 8'h00, 32'h0,        1, 32'hFFFFFFBE};
    tbl[14] = '{0, 3'b101, 8'hFE, 32'h0,        0, 32'h00001122};

    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mem_a", {24'd0, mem_a}, 32'd0);
    chk("reset mem_wd", {24'd0, mem_wd}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      init_we = 1; init_a = 8'(i); init_d = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    @(negedge clk);
    init_we = 0;
    rst = 0;

    foreach (tbl[i]) begin
      do_op(tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].d, e, r);
      chk("table err", {31'd0, e}, {31'd0, tbl[i].e});
      chk("table rdata", r, tbl[i].r);
    end

    // reset after the second byte of a word store
    @(negedge clk);
    req = 1; we = 1; funct3 = 3'b010; addr = 8'h20; wdata = 32'hAABBCCDD;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mem_we before abort", {31'd0, mem_we}, 32'd1);
    rst = 1;
    #1;
    chk("abort mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort mem_a", {24'd0, mem_a}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_done |= done;
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk("abort no done", {31'd0, saw_done}, 32'd0);
    chk("abort byte 0x20", {24'd0, mem[8'h20]}, 32'h000000DD);
    chk("abort byte 0x21", {24'd0, mem[8'h21]}, 32'h000000CC);
    chk("abort byte 0x22", {24'd0, mem[8'h22]}, {24'd0, ref_mem[8'h22]});
    chk("abort byte 0x23", {24'd0, mem[8'h23]}, {24'd0, ref_mem[8'h23]});
    ref_mem[8'h20] = 8'hDD;
    ref_mem[8'h21] = 8'hCC;
    ref_rdata = 0;

    // req held high with SB: one acceptance every three cycles
    @(negedge clk);
    req = 1; we = 1; funct3 = 3'b000; addr = 8'h40; wdata = 32'h0000005A;
    n_done = 0; prev = 0; adj = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (done && prev) adj = 1;
      prev = done;
    end
    req = 0;
    ref_mem[8'h40] = 8'h5A;
    chk("held req done count", 32'(n_done), 32'd4);
    chk("held req adjacent done", {31'd0, adj}, 32'd0);
    @(negedge clk);
    chk("held req idle", {31'd0, busy}, 32'd0);
    chk("held req byte", {24'd0, mem[8'h40]}, 32'h0000005A);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, e, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 8, byte-address width of the data-memory port.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  core access request, sampled in IDLE only.
REQ-005 we  input  1  1 = store, 0 = load; sampled with req.
REQ-006 funct3  input  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  ADDR_W  byte address, sampled with req.
REQ-008 wdata  input  32  store data, sampled with req.
REQ-009 busy  output  1  high while state != IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  valid with done; 1 = access rejected.
REQ-012 rdata  output  32  load result, valid from the done cycle and held until the next done.
REQ-013 mem_a  output  ADDR_W  byte address to the data memory.
REQ-014 mem_wd  output  8  write byte to the data memory.
REQ-015 mem_we  output  1  write enable to the data memory.
REQ-016 mem_rd  input  8  combinational read byte from the data memory, i.e. memory content at mem_a in the same cycle.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, and DONE.
REQ-018 IDLE SHALL be left only on req=1; req SHALL be ignored in ACCESS and DONE.
REQ-019 The unit SHALL reject a request when funct3 is not in {000,001,010,100,101}, when a store uses funct3 100 or 101, when a halfword has addr[0]=1, or when a word has addr[1:0]!=0.
REQ-020 On a rejected request, IDLE SHALL go to DONE with err=1, no mem_we assertion, and rdata unchanged.
REQ-021 On an accepted request, the unit SHALL latch we, funct3, addr and wdata; set N = 1/2/4 bytes; clear byte counter k; and go to ACCESS.
REQ-022 In ACCESS, mem_a SHALL equal latched addr + k; k SHALL increment each cycle; the state SHALL go to DONE after the cycle with k = N-1.
REQ-023 Because alignment is enforced, address wrap-around SHALL never occur within one access.
REQ-024 For a store in ACCESS, mem_we SHALL be 1 and mem_wd SHALL be wdata byte k (little-endian: byte 0 = bits 7:0).
REQ-025 For a load in ACCESS, mem_we SHALL be 0 and mem_rd SHALL be captured into buffer byte k at the clock edge.
REQ-026 Outside ACCESS, or for a load, mem_we SHALL be 0 and mem_wd SHALL be 0; outside ACCESS, mem_a SHALL be 0.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-028 In the DONE cycle of a load, rdata SHALL be updated as follows: B/H sign-extended from bit 7/15, BU/HU zero-extended, W unchanged.
REQ-029 A store SHALL leave rdata unchanged.
REQ-030 Latency: with req sampled at edge 0, done SHALL be high in cycle N+1 (accepted) or cycle 1 (rejected).
REQ-031 Back-to-back operation: a req high in the DONE cycle SHALL be ignored; the next acceptance SHALL be no earlier than the IDLE cycle after DONE.
REQ-032 err SHALL be 0 whenever done is 0.

Reset
REQ-033 While rst=1, asynchronously: state SHALL be IDLE; busy, done, err, and mem_we SHALL be 0; rdata SHALL be 0x00000000; mem_a and mem_wd SHALL be 0; k SHALL be 0.
REQ-034 A reset asserted mid-ACCESS SHALL drop mem_we immediately; bytes already written SHALL remain in memory; no done SHALL be issued for the aborted access.
REQ-035 After rst deasserts, the first rising edge SHALL be able to accept a req.

Verification
REQ-036 SW addr=0x10 wdata=0xDEADBEEF -> mem writes 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE on 4 consecutive cycles; done in cycle 5; err=0.
REQ-037 After REQ-036, LW addr=0x10 -> rdata=0xDEADBEEF in cycle 5; LB addr=0x13 -> 0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x12 -> 0x0000DEAD.
REQ-038 LW addr=0x11, SH addr=0x03, and SB with funct3=100 -> each yields done with err=1 in cycle 1, mem_we never high, and rdata unchanged.
REQ-039 SW addr=0xFC wdata=0x11223344 -> bytes written at 0xFC..0xFF with no wrap; LW 0xFC -> 0x11223344.
REQ-040 rst pulsed after the 2nd byte of SW 0x20 data 0xAABBCCDD -> mem_we falls immediately; 0x20=DD, 0x21=CC written; 0x22 and 0x23 unchanged; no done; busy=0.
REQ-041 req held high continuously with SB -> accepted once every 3 cycles (IDLE, ACCESS, DONE); done pulses are never adjacent.
